// File: rtl/byte_strip_pkg.sv
// rtl/byte_strip_pkg.sv - shared types and constants for the byte-striping lane scheduler
package byte_strip_pkg;

    localparam int WORD_W    = 9;
    localparam int VALID_BIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ODD  = 2'd1,
        PAD  = 2'd2
    } state_e;

    // Lane enable encodings: bit0 = lane0, bit1 = lane1
    localparam logic [1:0] CFG_OFF  = 2'b00;
    localparam logic [1:0] CFG_L0   = 2'b01;
    localparam logic [1:0] CFG_L1   = 2'b10;
    localparam logic [1:0] CFG_BOTH = 2'b11;

    localparam logic [7:0] DEFAULT_PAD_BYTE = 8'hBC;

endpackage

// File: rtl/lane_hold_reg.sv
// rtl/lane_hold_reg.sv - one-entry lane beat holding register with completion counter
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i, byte_i : load {1, byte_i}; caller only loads when free_o is high
//   ready_i        : lane consumer accepts the held beat this cycle
//   free_o         : register can take a new beat this cycle
//   beat_o         : held beat, [8] = valid
//   cnt_o          : completed handshakes, wraps
module lane_hold_reg
    import byte_strip_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    input  logic              ready_i,
    output logic              free_o,
    output logic [WORD_W-1:0] beat_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [WORD_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done;

    always_comb begin
        done   = beat_q[VALID_BIT] && ready_i;
        // Free in the completing cycle so back-to-back beats need no bubble
        free_o = !beat_q[VALID_BIT] || ready_i;
        beat_d = beat_q;
        if (done) begin
            beat_d = '0;
        end
        if (load_i) begin
            beat_d = {1'b1, byte_i};
        end
        cnt_d = cnt_q + CNT_W'(done);
    end

    // Reset drops a held beat without counting it
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beat_q <= '0;
            cnt_q  <= '0;
        end else begin
            beat_q <= beat_d;
            cnt_q  <= cnt_d;
        end
    end

    assign beat_o = beat_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/byte_strip_lane_scheduler.sv
// rtl/byte_strip_lane_scheduler.sv - alternates an input byte stream onto two lanes with pad alignment
//   clk2f, reset         : clock, synchronous active-high reset
//   in_data, in_ready    : input word [8]=valid [7:0]=byte, accepted when valid && in_ready
//   lane_en              : requested lane enables, sampled only between byte pairs
//   lane0/1, lane0/1_ready : registered lane beats and their consumer handshakes
//   sent0, sent1         : completed beats per lane (lane1 includes pads)
//   busy                 : pair in progress or a lane still holds a beat
module byte_strip_lane_scheduler
    import byte_strip_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = DEFAULT_PAD_BYTE,
    parameter int         PAD_WAIT = 4,
    parameter int         CNT_W    = 16
) (
    input  logic              clk2f,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic [1:0]        lane_en,
    input  logic              lane0_ready,
    input  logic              lane1_ready,
    output logic [WORD_W-1:0] lane0,
    output logic [WORD_W-1:0] lane1,
    output logic [CNT_W-1:0]  sent0,
    output logic [CNT_W-1:0]  sent1,
    output logic              busy
);

    state_e     state_q, state_d;
    logic [1:0] cfg_q, cfg_d;
    logic [7:0] timer_q, timer_d;
    logic       free0, free1;
    logic       load0, load1;
    logic [7:0] byte1;
    logic       tgt1;
    logic       accept;
    logic       stall;

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        timer_d = timer_q;
        load0   = 1'b0;
        load1   = 1'b0;
        byte1   = in_data[7:0];

        tgt1     = (state_q == ODD) || (cfg_q == CFG_L1);
        in_ready = !reset && (tgt1 ? free1 : free0)
                   && (state_q != PAD) && (cfg_q != CFG_OFF);
        accept   = in_data[VALID_BIT] && in_ready;
        // Data waiting on a busy lane1 is not idleness; do not count it toward a pad
        stall    = in_data[VALID_BIT] && !free1;

        // Enable changes only take effect between pairs
        if (state_q == IDLE) begin
            cfg_d = lane_en;
        end

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (accept) begin
                    load0 = !tgt1;
                    load1 = tgt1;
                    if (cfg_q == CFG_BOTH) begin
                        state_d = ODD;
                    end
                end
            end
            ODD: begin
                if (accept) begin
                    load1   = 1'b1;
                    state_d = IDLE;
                    timer_d = '0;
                end else if (!stall) begin
                    timer_d = timer_q + 8'd1;
                    if (timer_d == 8'(PAD_WAIT)) begin
                        state_d = PAD;
                        timer_d = '0;
                    end
                end
            end
            PAD: begin
                byte1 = PAD_BYTE;
                if (free1) begin
                    load1   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk2f) begin
        if (reset) begin
            state_q <= IDLE;
            cfg_q   <= CFG_BOTH;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            timer_q <= timer_d;
        end
    end

    lane_hold_reg #(.CNT_W(CNT_W)) u_lane0 (
        .clk_i   (clk2f),
        .reset_i (reset),
        .load_i  (load0),
        .byte_i  (in_data[7:0]),
        .ready_i (lane0_ready),
        .free_o  (free0),
        .beat_o  (lane0),
        .cnt_o   (sent0)
    );

    lane_hold_reg #(.CNT_W(CNT_W)) u_lane1 (
        .clk_i   (clk2f),
        .reset_i (reset),
        .load_i  (load1),
        .byte_i  (byte1),
        .ready_i (lane1_ready),
        .free_o  (free1),
        .beat_o  (lane1),
        .cnt_o   (sent1)
    );

    assign busy = (state_q != IDLE) || lane0[VALID_BIT] || lane1[VALID_BIT];

endmodule
